alu_result_checker: RTL
=======================

Name: alu_result_checker

Overview:
- Synthesizable, self-checking response side for alu_32_bit.
- Accepts each applied vector (a, b, S2..S0, Ci) together with the ALU's observed F/Co, recomputes the expected result with an internal golden model, compares the two, and keeps pass/fail statistics.
- Sits beside the ALU in bring-up and regression benches; turns stimulus-only runs into pass/fail runs without reading $monitor logs.

Parameters:
- WIDTH, 32, operand/result width.
- NUM_VEC, 16, vectors per run; range 1..65535.
- CNT_W, 16, width of all counters and indices.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: clear statistics, begin a run.
- in_valid  input  1  vector and observed result present this cycle.
- in_ready  output  1  checker accepts this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sel  input  3  {S2,S1,S0} op select.
- ci  input  1  carry in.
- f_obs  input  WIDTH  ALU F output.
- co_obs  input  1  ALU Co output.
- busy  output  1  state is RUN or DRAIN.
- done  output  1  state is DONE.
- pass_cnt  output  CNT_W  vectors that matched.
- fail_cnt  output  CNT_W  vectors that mismatched.
- err  output  1  sticky; set on the first mismatch of a run.
- fail_idx  output  CNT_W  index (0-based) of the first failing vector.
- fail_exp  output  WIDTH+1  {Co,F} expected at first failure.
- fail_got  output  WIDTH+1  {Co,F} observed at first failure.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All counters, indices, fail_exp, fail_got = 0.
  - err=0, busy=0, done=0, in_ready=0.
  - Pipeline valid bits are cleared.
  - Reset mid-run aborts the run; nothing is retained.
- Golden model, result={Co,F}, computed at WIDTH+1 bits:
  - 000: a+b+ci.
  - 001: a+~b+ci.
  - 010: a+ci.
  - 011: ~a, Co=0.
  - 100: a&b, Co=0.
  - 101: a^b, Co=0.
  - 110: ~(a|b), Co=0.
  - 111: a|b, Co=0.
- Handshake:
  - in_ready=1 only in RUN while accepted count < NUM_VEC.
  - A vector is accepted on a clock where in_valid&in_ready.
  - in_valid outside that condition is ignored and no state changes.
- Pipeline, fixed 2-cycle latency:
  - Stage 1 registers a, b, sel, ci, f_obs, co_obs and the vector index.
  - Stage 2 computes the expected result, compares, and registers the match bit.
  - Statistics update on the clock edge after stage 2, so counters reflect vector k two cycles after its acceptance edge.
  - Back-to-back acceptance every cycle is supported.
- Statistics:
  - Match increments pass_cnt.
  - Mismatch increments fail_cnt.
  - On the first mismatch of a run only, also set err and load fail_idx, fail_exp and fail_got. Later mismatches never overwrite them.
  - Counters saturate at 2^CNT_W-1.
- FSM, one state register:
  - IDLE: start -> RUN and clear statistics.
  - RUN: the NUM_VEC-th accept -> DRAIN.
  - DRAIN: wait until both pipeline stages are empty (2 cycles), then -> DONE.
  - DONE: done=1 and outputs hold; start -> RUN and clear statistics.
- start is ignored in RUN/DRAIN; no restart mid-run.
- start and in_valid in the same cycle in IDLE/DONE: start takes effect and the vector is not accepted; in_ready rises the next cycle.
- Invariant at DONE: pass_cnt+fail_cnt = NUM_VEC.

Test Plan:
- NUM_VEC=4, all OR vectors, where ALU F equals a|b for each: a=0x01010101, b=0x61616161 -> F=0x61616161; a=0x0101010F, b=0x61216061 -> F=0x6121616F; a=0x25010107, b=0x61616167 -> F=0x65616167; a=0xA5010107, b=0x61656167 -> F=0xE5656167 -> done after accept+2, pass_cnt=4, fail_cnt=0, err=0.
- Carry check: sel=000, a=0xFFFFFFFF, b=1, ci=0, f_obs=0, co_obs=1 -> pass. Same vector with co_obs=0 -> err=1, fail_exp=0x1_00000000, fail_got=0x0_00000000.
- Mismatch injection on vectors 2 and 3 of 4 -> fail_cnt=2, fail_idx=2, captured values belong to vector 2 only.
- in_valid held high for 6 cycles with NUM_VEC=4 -> exactly 4 accepted; in_ready low from cycle 5 on; the extra vectors do not affect counters.
- rst_n pulsed low after 2 of 4 vectors accepted -> all outputs 0 immediately (async); the following start runs 4 fresh vectors correctly.
- start pulsed while in DONE -> counters and err clear on the next edge, busy=1, in_ready=1.

Source files
------------

// File: rtl/alu_result_checker.sv
// Response-side checker for alu_32_bit: recomputes {Co,F} for each accepted vector, compares it
// with the observed result two cycles later, and tracks pass/fail counts plus the first failure.
module alu_result_checker #(
  parameter int WIDTH   = 32,
  parameter int NUM_VEC = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             ci,
  input  logic [WIDTH-1:0] f_obs,
  input  logic             co_obs,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH:0]   fail_exp,
  output logic [WIDTH:0]   fail_got
);

  localparam int W1 = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;

  logic             s1_vld_q, s1_vld_d, s1_ci_q, s1_ci_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2:0]       s1_sel_q, s1_sel_d;
  logic [WIDTH:0]   s1_got_q, s1_got_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;

  logic             s2_vld_q, s2_vld_d, s2_match_q, s2_match_d;
  logic [WIDTH:0]   s2_exp_q, s2_exp_d, s2_got_q, s2_got_d;
  logic [CNT_W-1:0] s2_idx_q, s2_idx_d;

  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d, fail_idx_q, fail_idx_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;

  logic [WIDTH:0]   exp_res;
  logic             accept, start_ok;

  // Golden model; arithmetic ops carry out through the extra top bit.
  always_comb begin
    exp_res = '0;
    unique case (s1_sel_q)
      3'b000:  exp_res = {1'b0, s1_a_q} + {1'b0, s1_b_q} + W1'(s1_ci_q);
      3'b001:  exp_res = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + W1'(s1_ci_q);
      3'b010:  exp_res = {1'b0, s1_a_q} + W1'(s1_ci_q);
      3'b011:  exp_res = {1'b0, ~s1_a_q};
      3'b100:  exp_res = {1'b0, s1_a_q & s1_b_q};
      3'b101:  exp_res = {1'b0, s1_a_q ^ s1_b_q};
      3'b110:  exp_res = {1'b0, ~(s1_a_q | s1_b_q)};
      default: exp_res = {1'b0, s1_a_q | s1_b_q};
    endcase
  end

  always_comb begin
    accept   = in_valid && in_ready_q;
    start_ok = start && (state_q == IDLE || state_q == DONE);

    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q;
    s1_vld_d   = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    s1_ci_d    = s1_ci_q;
    s1_got_d   = s1_got_q;
    s1_idx_d   = s1_idx_q;
    s2_vld_d   = s1_vld_q;
    s2_match_d = s2_match_q;
    s2_exp_d   = s2_exp_q;
    s2_got_d   = s2_got_q;
    s2_idx_d   = s2_idx_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    fail_idx_d = fail_idx_q;
    fail_exp_d = fail_exp_q;
    fail_got_d = fail_got_q;

    if (accept) begin
      s1_a_d    = a;
      s1_b_d    = b;
      s1_sel_d  = sel;
      s1_ci_d   = ci;
      s1_got_d  = {co_obs, f_obs};
      s1_idx_d  = acc_cnt_q;
      acc_cnt_d = acc_cnt_q + 1'b1;
    end

    if (s1_vld_q) begin
      s2_match_d = (exp_res == s1_got_q);
      s2_exp_d   = exp_res;
      s2_got_d   = s1_got_q;
      s2_idx_d   = s1_idx_q;
    end

    if (s2_vld_q) begin
      if (s2_match_q) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
      end else begin
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
        if (!err_q) begin
          err_d      = 1'b1;
          fail_idx_d = s2_idx_q;
          fail_exp_d = s2_exp_q;
          fail_got_d = s2_got_q;
        end
      end
    end

    unique case (state_q)
      IDLE, DONE: if (start_ok) state_d = RUN;
      RUN:        if (accept && acc_cnt_q == LAST_IDX) state_d = DRAIN;
      default:    if (!s1_vld_q) state_d = DONE;  // last vector retires on this edge
    endcase

    if (start_ok) begin
      acc_cnt_d  = '0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
      fail_idx_d = '0;
      fail_exp_d = '0;
      fail_got_d = '0;
    end

    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sel_q   <= '0;
      s1_ci_q    <= 1'b0;
      s1_got_q   <= '0;
      s1_idx_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_match_q <= 1'b0;
      s2_exp_q   <= '0;
      s2_got_q   <= '0;
      s2_idx_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      fail_idx_q <= '0;
      fail_exp_q <= '0;
      fail_got_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s1_vld_q   <= s1_vld_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sel_q   <= s1_sel_d;
      s1_ci_q    <= s1_ci_d;
      s1_got_q   <= s1_got_d;
      s1_idx_q   <= s1_idx_d;
      s2_vld_q   <= s2_vld_d;
      s2_match_q <= s2_match_d;
      s2_exp_q   <= s2_exp_d;
      s2_got_q   <= s2_got_d;
      s2_idx_q   <= s2_idx_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      fail_idx_q <= fail_idx_d;
      fail_exp_q <= fail_exp_d;
      fail_got_q <= fail_got_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign err      = err_q;
  assign fail_idx = fail_idx_q;
  assign fail_exp = fail_exp_q;
  assign fail_got = fail_got_q;

endmodule
